sdram_frame_writer: RTL and testbench
=====================================

// Module: sdram_frame_writer
// PURPOSE
//   Wishbone initiator that feeds camera pixels into the SDRAM controller's Wishbone responder port.
//   - Packs 16-bit RGB565 pixels in pairs into 32-bit words and buffers them in a small FIFO.
//   - Issues single write cycles to consecutive frame-buffer addresses.
//   - Restarts at BASE_ADDR on each frame_start_i.
//   - Sits between the camera capture block and the SDRAM controller, on the same clk_i domain.
// PARAMETERS
//   BASE_ADDR    25'd0     frame buffer start address ({bank,row,col})
//   FRAME_WORDS  38400     32-bit words per frame (320x240 px / 2)
//   ADDR_STRIDE  2         address increment per word (BL=2, 16-bit columns)
//   FIFO_DEPTH   16        word FIFO depth, power of 2
//   ACK_TIMEOUT  255       max cycles from strobe to ack_i before abort
// PORTS
//   clk_i          in   1   system clock, 100 MHz
//   rst_ni         in   1   asynchronous reset, active low
//   frame_start_i  in   1   1-cycle pulse; a new frame begins
//   pix_valid_i    in   1   pix_data_i valid this cycle; cannot be stalled
//   pix_data_i     in   16  RGB565 pixel
//   addr_o         out  25  Wishbone address
//   dat_o          out  32  Wishbone write data
//   we_o           out  1   Wishbone write enable; always 1 during a cycle
//   stb_o          out  1   Wishbone strobe, 1-cycle pulse per request
//   cyc_o          out  1   Wishbone cycle, held until ack_i or timeout
//   ack_i          in   1   Wishbone acknowledge
//   frame_done_o   out  1   1-cycle pulse when the last word of a frame is acked
//   overflow_o     out  1   sticky: a word was dropped because the FIFO was full
//   timeout_o      out  1   sticky: a cycle was aborted because ack_i never arrived
// BEHAVIOUR
//   Reset: all outputs are 0. FIFO is empty. Pack phase is 0. Address is BASE_ADDR. FSM is IDLE.
//   Packing
//   - The first pixel of a pair goes to word[31:16]; the second goes to word[15:0].
//   - The completed word is pushed to the FIFO in the cycle after the second pixel.
//   Overflow
//   - A push while the FIFO is full drops the word and sets overflow_o.
//   - The FIFO contents are not altered.
//   FSM
//   - IDLE -> REQ when the FIFO is not empty and words_sent < FRAME_WORDS.
//   - REQ, 1 cycle: stb_o=1, cyc_o=1, we_o=1, addr_o/dat_o from the FIFO head. -> WAIT_ACK.
//   - WAIT_ACK: stb_o=0, cyc_o=1, addr_o/dat_o held.
//     - On ack_i: pop the FIFO, add ADDR_STRIDE to the address, increment words_sent. -> GAP.
//     - When the timeout counter reaches ACK_TIMEOUT without ack_i: set timeout_o, pop, advance. -> GAP.
//   - GAP, 1 cycle: cyc_o=0. -> IDLE.
//   Strobe rule
//   - stb_o is never held for more than 1 cycle, because the SDRAM controller re-latches any strobe still high.
//   - An ack_i that arrives in the same cycle as REQ is accepted. It is treated as in WAIT_ACK.
//   Frame end
//   - The ack of word FRAME_WORDS-1 pulses frame_done_o in the next cycle.
//   - Words pushed after that are discarded at the FIFO output without a bus cycle.
//   frame_start_i
//   - Clears the pack phase (an odd leftover pixel is discarded), words_sent, and the address (reset to BASE_ADDR).
//   - Clears the FIFO, overflow_o and timeout_o.
//   - A bus cycle in flight (REQ/WAIT_ACK) completes normally. Its pop and advance are suppressed.
//   - frame_start_i and pix_valid_i in the same cycle: the pixel is the first of the new frame.
//   Push and pop in the same cycle when the FIFO is full: the push succeeds and no overflow occurs.
//   Address arithmetic is modulo 2^25 and wraps silently.
//   Reset assertion mid-cycle drops cyc_o and stb_o immediately.
// STRUCTURE
//   Shared package sdram_pkg holds the Wishbone widths (ADDR_W=25, DATA_W=32) and the FSM state encoding.
//   The word buffer is one sub-module, sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/clear).
// TESTING
//   1. 8 pixels 0x1111..0x8888, responder acks 12 cycles after strobe:
//      - 4 writes at addr 0,2,4,6 with data 0x11112222, 0x33334444, 0x55556666, 0x77778888.
//      - Every stb_o lasts exactly 1 cycle.
//   2. FRAME_WORDS=4, 10 pixels:
//      - exactly 4 bus cycles;
//      - frame_done_o pulses once, 1 cycle after the 4th ack;
//      - the 5th word is never issued.
//   3. Responder never acks, ACK_TIMEOUT=255:
//      - cyc_o drops 255 cycles after the strobe;
//      - timeout_o=1;
//      - the next request uses addr 2.
//   4. Responder stalled, 2*(FIFO_DEPTH+2) pixels sent:
//      - overflow_o=1;
//      - the first 16 words are written intact once acks resume.
//   5. 3 pixels, then frame_start_i mid-WAIT_ACK:
//      - the in-flight cycle finishes;
//      - the odd pixel is dropped;
//      - the next frame's first write goes to BASE_ADDR.
//   6. rst_ni low during WAIT_ACK: stb_o, cyc_o and all flags are 0 in the same cycle, and the FIFO is empty.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared Wishbone widths and FSM encoding for the SDRAM frame writer.
package sdram_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PIX_W  = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitAck = 2'd2,
        StGap     = 2'd3
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; clear has priority, and a push into a full FIFO succeeds if a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes them to consecutive frame-buffer
// addresses through single Wishbone write cycles.
module sdram_frame_writer
    import sdram_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       FRAME_WORDS = 38400,
    parameter int unsigned       ADDR_STRIDE = 2,
    parameter int unsigned       FIFO_DEPTH  = 16,
    parameter int unsigned       ACK_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_start_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              we_o,
    output logic              stb_o,
    output logic              cyc_o,
    input  logic              ack_i,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    localparam int unsigned CntW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 2);

    wb_state_e         state_q, state_d;
    logic              phase_q;
    logic [PIX_W-1:0]  hi_q;
    logic [DATA_W-1:0] word_q;
    logic              push_pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CntW-1:0]   words_q;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              abort_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_dat_q;
    logic              done_q, ovf_q, tmo_flag_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              busy, bus_end, tmo_evt, idle_drop, advance;

    assign busy = (state_q == StReq) || (state_q == StWaitAck);

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        bus_end   = 1'b0;
        tmo_evt   = 1'b0;
        idle_drop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !frame_start_i) begin
                    // Words beyond the end of the frame are discarded without a bus cycle.
                    if (words_q < CntW'(FRAME_WORDS)) state_d = StReq;
                    else                              idle_drop = 1'b1;
                end
            end
            StReq: begin
                tmo_cnt_d = TmoW'(1);
                if (ack_i) begin
                    bus_end = 1'b1;
                    state_d = StGap;
                end else begin
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (ack_i) begin
                    bus_end = 1'b1;
                    state_d = StGap;
                end else if (tmo_cnt_q + TmoW'(1) == TmoW'(ACK_TIMEOUT)) begin
                    bus_end = 1'b1;
                    tmo_evt = 1'b1;
                    state_d = StGap;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A cycle started before frame_start_i belongs to the old frame: no pop, no advance.
    assign advance   = bus_end && !abort_q && !frame_start_i;
    assign fifo_pop  = advance || idle_drop;
    assign fifo_push = push_pend_q && !frame_start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tmo_cnt_q  <= '0;
            abort_q    <= 1'b0;
            bus_addr_q <= '0;
            bus_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            if (frame_start_i && busy)  abort_q <= 1'b1;
            else if (state_q == StGap)  abort_q <= 1'b0;
            if (state_q == StIdle && state_d == StReq) begin
                bus_addr_q <= addr_q;
                bus_dat_q  <= fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= 1'b0;
            hi_q        <= '0;
            word_q      <= '0;
            push_pend_q <= 1'b0;
        end else begin
            push_pend_q <= 1'b0;
            if (frame_start_i) begin
                phase_q <= pix_valid_i;
                if (pix_valid_i) hi_q <= pix_data_i;
            end else if (pix_valid_i) begin
                if (!phase_q) begin
                    hi_q    <= pix_data_i;
                    phase_q <= 1'b1;
                end else begin
                    word_q      <= {hi_q, pix_data_i};
                    push_pend_q <= 1'b1;
                    phase_q     <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= BASE_ADDR;
            words_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            done_q     <= advance && ack_i && (words_q == CntW'(FRAME_WORDS - 1));
            tmo_flag_q <= (tmo_flag_q && !frame_start_i) || tmo_evt;
            if (frame_start_i) begin
                addr_q  <= BASE_ADDR;
                words_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (advance) begin
                    addr_q  <= addr_q + ADDR_W'(ADDR_STRIDE);
                    words_q <= words_q + CntW'(1);
                end
                if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (frame_start_i),
        .push  (fifo_push),
        .wdata (word_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign stb_o        = (state_q == StReq);
    assign cyc_o        = busy;
    assign we_o         = busy;
    assign addr_o       = bus_addr_q;
    assign dat_o        = bus_dat_q;
    assign frame_done_o = done_q;
    assign overflow_o   = ovf_q;
    assign timeout_o    = tmo_flag_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Scoreboard bench for sdram_frame_writer: a full-size instance plus a 4-word-frame instance.
module tb_sdram_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;

    logic [24:0] addr, addr4;
    logic [31:0] dat, dat4;
    logic        we, stb, cyc, ack, done, ovf, tmo;
    logic        we4, stb4, cyc4, ack4, done4, ovf4, tmo4;

    int errors = 0;
    int checks = 0;

    logic [56:0] exp_q[$];
    logic [15:0] m_hi = '0;
    logic        m_phase = 1'b0;
    logic [24:0] m_addr = '0;

    int ack_delay = 12;
    int wcnt = 0;
    int wcnt4 = 0;
    logic prev_stb = 1'b0;

    always #5 clk = ~clk;

    sdram_frame_writer dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .pix_valid_i(pix_valid),
        .pix_data_i(pix_data), .addr_o(addr), .dat_o(dat), .we_o(we), .stb_o(stb), .cyc_o(cyc),
        .ack_i(ack), .frame_done_o(done), .overflow_o(ovf), .timeout_o(tmo)
    );

    sdram_frame_writer #(.FRAME_WORDS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .pix_valid_i(pix_valid),
        .pix_data_i(pix_data), .addr_o(addr4), .dat_o(dat4), .we_o(we4), .stb_o(stb4),
        .cyc_o(cyc4), .ack_i(ack4), .frame_done_o(done4), .overflow_o(ovf4), .timeout_o(tmo4)
    );

    // Responders: ack arrives ack_delay cycles after the strobe cycle.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ack = 1'b0; wcnt = 0;
        end else if (stb) begin
            ack = 1'b0; wcnt = ack_delay;
        end else if (wcnt > 0) begin
            wcnt--; ack = (wcnt == 0);
        end else begin
            ack = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ack4 = 1'b0; wcnt4 = 0;
        end else if (stb4) begin
            ack4 = 1'b0; wcnt4 = 2;
        end else if (wcnt4 > 0) begin
            wcnt4--; ack4 = (wcnt4 == 0);
        end else begin
            ack4 = 1'b0;
        end
    end

    // Monitor: strobe width and every acknowledged write against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stb) begin
                checks++;
                if (prev_stb) begin
                    errors++;
                    $display("FAIL stb_width: stb_o high 2 cycles, required 1 at %0t", $time);
                end
            end
            if (cyc && ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h dat=%h, required none", addr, dat);
                end else begin
                    logic [56:0] e;
                    e = exp_q.pop_front();
                    if ({we, addr, dat} !== {1'b1, e}) begin
                        errors++;
                        $display("FAIL write: we=%b addr=%h dat=%h, required we=1 addr=%h dat=%h",
                                 we, addr, dat, e[56:32], e[31:0]);
                    end
                end
            end
        end
        prev_stb = stb;
    end

    task automatic pulse_frame_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        m_phase = 1'b0;
        m_addr = '0;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Drives n pixels back to back; only the first `keep` completed words are expected on the bus.
    task automatic send_pixels(input int n, input int keep, input logic [15:0] start,
                               input logic [15:0] step);
        int kept = 0;
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            p = start + 16'(i) * step;
            pix_valid = 1'b1;
            pix_data = p;
            if (!m_phase) begin
                m_hi = p; m_phase = 1'b1;
            end else begin
                m_phase = 1'b0;
                if (kept < keep) begin
                    exp_q.push_back({m_addr, m_hi, p});
                    m_addr = m_addr + 25'd2;
                    kept++;
                end
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_stb(input string name);
        int n = 0;
        @(negedge clk);
        while (!stb && n < 500) begin
            n++; @(negedge clk);
        end
        if (!stb) begin
            errors++; checks++;
            $display("FAIL %s: no stb_o within 500 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            n++; @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({stb, cyc, we, done, ovf, tmo, addr, dat} !== '0 ||
            {stb4, cyc4, we4, done4, ovf4, tmo4, addr4, dat4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b cyc=%b done=%b ovf=%b tmo=%b addr=%h dat=%h, required 0",
                     stb, cyc, done, ovf, tmo, addr, dat);
        end
    endtask

    task automatic test_basic();
        ack_delay = 12;
        pulse_frame_start();
        send_pixels(8, 4, 16'h1111, 16'h1111);
        wait_drain("basic_drain");
        checks++;
        if (ovf !== 1'b0 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: ovf=%b tmo=%b, required 0 0", ovf, tmo);
        end
    endtask

    task automatic test_frame_end();
        int stbs = 0, acks = 0, dones = 0, last_ack = -10, done_at = -1;
        ack_delay = 12;
        pulse_frame_start();
        fork
            send_pixels(10, 5, 16'h0a00, 16'h0003);
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (stb4) stbs++;
                if (cyc4 && ack4) begin acks++; last_ack = c; end
                if (done4) begin dones++; done_at = c; end
            end
        join
        checks++;
        if (stbs != 4 || acks != 4) begin
            errors++;
            $display("FAIL frame_end_cycles: stb=%0d ack=%0d, required 4 4", stbs, acks);
        end
        checks++;
        if (dones != 1 || done_at != last_ack + 1) begin
            errors++;
            $display("FAIL frame_done: pulses=%0d at %0d, required 1 at %0d", dones, done_at,
                     last_ack + 1);
        end
        wait_drain("frame_end_drain");
    endtask

    task automatic test_timeout();
        int n = 0;
        ack_delay = 1000;
        pulse_frame_start();
        send_pixels(2, 1, 16'hc0de, 16'h0001);
        void'(exp_q.pop_front());
        wait_stb("timeout_stb");
        ack_delay = 12;
        fork
            send_pixels(2, 1, 16'hbee0, 16'h0011);
            while (cyc && n < 400) begin
                n++; @(negedge clk);
            end
        join
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL timeout_len: cyc_o high %0d cycles, required 255", n);
        end
        checks++;
        if (tmo !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: timeout_o=%b, required 1", tmo);
        end
        wait_drain("timeout_drain");
    endtask

    task automatic test_overflow();
        ack_delay = 150;
        pulse_frame_start();
        send_pixels(36, 16, 16'h0100, 16'h0101);
        @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: overflow_o=%b, required 1", ovf);
        end
        ack_delay = 2;
        wait_drain("overflow_drain");
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL overflow_tmo: timeout_o=%b, required 0", tmo);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int seen = 0;
        ack_delay = 12;
        send_pixels(4, 2, 16'h7000, 16'h0101);
        wait_stb("rst_stb");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({stb, cyc, done, ovf, tmo, addr, dat} !== '0) begin
            errors++;
            $display("FAIL reset_mid: stb=%b cyc=%b ovf=%b tmo=%b addr=%h dat=%h, required 0",
                     stb, cyc, ovf, tmo, addr, dat);
        end
        exp_q.delete();
        m_phase = 1'b0;
        m_addr = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (stb) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_fifo_empty: %0d strobes after reset, required 0", seen);
        end
    endtask

    task automatic test_frame_start_mid();
        ack_delay = 12;
        pulse_frame_start();
        fork
            send_pixels(3, 1, 16'h4440, 16'h0001);
            wait_stb("fs_mid_stb");
        join
        repeat (3) @(posedge clk);
        pulse_frame_start();
        send_pixels(2, 1, 16'haaaa, 16'h1111);
        wait_drain("fs_mid_drain");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        test_basic();
        test_frame_end();
        test_timeout();
        test_overflow();
        test_reset_mid_cycle();
        test_frame_start_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
